// File: rtl/mem_arb_6502.sv
// mem_arb_6502: arbitrates the shared synchronous block RAM between the 6502 core
// and the UART loader/debug port, stalling the core via RDY and re-fetching its access.
module mem_arb_6502 #(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_dout,
    output logic [DW-1:0] cpu_din,
    output logic          cpu_rdy,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    input  logic          ldr_hold,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_LDR = 2'd1,
        S_RET = 2'd2
    } state_t;

    localparam logic [7:0] RUN_LAST = 8'(MAX_CPU_RUN - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [7:0]    run_cnt_r;
    logic [7:0]    run_cnt_nxt_s;
    logic          gnt_s;
    logic          ack_r;
    logic          ack_nxt_s;
    logic [DW-1:0] rdata_r;
    logic [DW-1:0] rdata_nxt_s;

    assign cpu_din   = mem_rdata;
    assign ldr_ack   = ack_r;
    assign ldr_rdata = rdata_r;

    // state, run counter and loader response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_CPU;
            run_cnt_r <= 8'd0;
            ack_r     <= 1'b0;
            rdata_r   <= {DW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            run_cnt_r <= run_cnt_nxt_s;
            ack_r     <= ack_nxt_s;
            rdata_r   <= rdata_nxt_s;
        end
    end

    // grant decision and next state; the ack cycle masks a stale request
    always_comb begin
        state_nxt_s = state_r;
        gnt_s       = 1'b0;
        ack_nxt_s   = 1'b0;
        rdata_nxt_s = rdata_r;
        case (state_r)
            S_CPU: begin
                gnt_s = ldr_req & ~ack_r & (ldr_hold | (run_cnt_r == RUN_LAST));
                if (gnt_s) begin
                    state_nxt_s = S_LDR;
                end else begin
                    state_nxt_s = S_CPU;
                end
            end
            S_LDR: begin
                state_nxt_s = S_RET;
            end
            S_RET: begin
                state_nxt_s = S_CPU;
                ack_nxt_s   = 1'b1;
                rdata_nxt_s = mem_rdata;
            end
            default: begin
                state_nxt_s = S_CPU;
            end
        endcase
    end

    // saturating count of CPU cycles granted while the loader waits
    always_comb begin
        run_cnt_nxt_s = run_cnt_r;
        if (!ldr_req || ack_r || gnt_s) begin
            run_cnt_nxt_s = 8'd0;
        end else if ((state_r == S_CPU) && (run_cnt_r != 8'hFF)) begin
            run_cnt_nxt_s = run_cnt_r + 8'd1;
        end else begin
            run_cnt_nxt_s = run_cnt_r;
        end
    end

    // RAM port mux; a stalled CPU write is never issued
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_dout;
        mem_we    = 1'b0;
        cpu_rdy   = 1'b0;
        case (state_r)
            S_CPU: begin
                cpu_rdy = ~ldr_hold;
                mem_we  = cpu_we & ~ldr_hold;
            end
            S_LDR: begin
                mem_addr  = ldr_addr;
                mem_we    = ldr_we;
                mem_wdata = ldr_wdata;
            end
            S_RET: begin
                mem_we = 1'b0;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    mem_arb_6502_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .ldr_req (ldr_req),
        .ldr_ack (ack_r),
        .cpu_rdy (cpu_rdy),
        .mem_we  (mem_we),
        .in_cpu  (state_r == S_CPU),
        .in_ldr  (state_r == S_LDR)
    );

endmodule

// mem_arb_6502_chk: protocol and safety properties of the arbiter.
module mem_arb_6502_chk (
    input logic clk,
    input logic reset_n,
    input logic ldr_req,
    input logic ldr_ack,
    input logic cpu_rdy,
    input logic mem_we,
    input logic in_cpu,
    input logic in_ldr
);

    a_req_held: assert property (@(posedge clk) disable iff (!reset_n)
        (ldr_req && !ldr_ack) |=> (ldr_req || ldr_ack));

    a_req_in_slot: assert property (@(posedge clk) disable iff (!reset_n)
        !in_cpu |-> ldr_req);

    a_ack_pulse: assert property (@(posedge clk) disable iff (!reset_n)
        ldr_ack |=> !ldr_ack);

    a_no_stalled_write: assert property (@(posedge clk) disable iff (!reset_n)
        (mem_we && !cpu_rdy) |-> in_ldr);

    a_stall_outside_cpu: assert property (@(posedge clk) disable iff (!reset_n)
        !in_cpu |-> !cpu_rdy);

endmodule

// File: tb/tb_mem_arb_6502.sv
// tb_mem_arb_6502: directed scoreboard bench for mem_arb_6502 with a synchronous RAM model.
module tb_mem_arb_6502;

    localparam int AW      = 16;
    localparam int DW      = 8;
    localparam int MAX_RUN = 4;

    typedef struct {
        bit         chk;
        logic [7:0] d;
    } ldr_exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cpu_addr;
    logic          cpu_we;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_din;
    logic          cpu_rdy;
    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_hold;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [7:0]  ram [0:65535];
    logic        pl_en   = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data = 8'h00;

    int n_cmp      = 0;
    int n_bad      = 0;
    int cyc        = 0;
    int ack_cnt    = 0;
    int wr0400_cnt = 0;
    int wr0400_cyc = -1;

    bit log_rdy [0:4095];
    bit log_we  [0:4095];
    bit log_ack [0:4095];

    logic       cpu_trk     = 1'b0;
    logic       cpu_rd_done = 1'b0;
    logic [7:0] cpu_q [$];
    ldr_exp_t   ldr_q [$];
    logic [7:0] mon_exp;
    ldr_exp_t   mon_le;

    always #5 clk = ~clk;

    mem_arb_6502 #(.AW(AW), .DW(DW), .MAX_CPU_RUN(MAX_RUN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_rdy   (cpu_rdy),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_hold  (ldr_hold),
        .ldr_ack   (ldr_ack),
        .ldr_rdata (ldr_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // block RAM: read-before-write, one-cycle read latency, plus a preload port
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            if (mem_addr == 16'h0400) begin
                wr0400_cnt <= wr0400_cnt + 1;
                wr0400_cyc <= cyc;
            end
        end
        if (pl_en) ram[pl_addr] <= pl_data;
        mem_rdata <= ram[mem_addr];
    end

    // per-cycle log of handshake signals
    always @(posedge clk) begin
        log_rdy[cyc[11:0]] <= cpu_rdy;
        log_we[cyc[11:0]]  <= mem_we;
        log_ack[cyc[11:0]] <= ldr_ack;
        ack_cnt     <= ack_cnt + (ldr_ack ? 1 : 0);
        cpu_rd_done <= reset_n & cpu_rdy & ~cpu_we & cpu_trk;
        cyc         <= cyc + 1;
    end

    function automatic bit lg_rdy(input int c);
        return log_rdy[c[11:0]];
    endfunction
    function automatic bit lg_we(input int c);
        return log_we[c[11:0]];
    endfunction
    function automatic bit lg_ack(input int c);
        return log_ack[c[11:0]];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: pops expectations whenever the DUT presents read data
    always @(negedge clk) begin
        if (cpu_rd_done) begin
            if (cpu_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL cpu_din: unexpected completion, got 0x%0h, expected none", cpu_din);
            end else begin
                mon_exp = cpu_q.pop_front();
                chk("cpu_din", int'(cpu_din), int'(mon_exp));
            end
        end
        if (ldr_ack) begin
            if (ldr_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL ldr_ack: unexpected ack, got 1, expected 0");
            end else begin
                mon_le = ldr_q.pop_front();
                if (mon_le.chk) chk("ldr_rdata", int'(ldr_rdata), int'(mon_le.d));
                else            chk("ldr_ack_match", int'(ldr_ack), 1);
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic cpu_acc(input logic [15:0] a, input logic we, input logic [7:0] d,
                           input logic trk, input logic [7:0] exp);
        int n = 0;
        cpu_addr = a; cpu_we = we; cpu_dout = d; cpu_trk = trk & ~we;
        if (trk && !we) cpu_q.push_back(exp);
        #1;
        while (!cpu_rdy && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!cpu_rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL cpu_stall_bound: rdy %0b after %0d cycles, expected 1", cpu_rdy, n);
        end
        @(negedge clk);
    endtask

    task automatic ldr_op(input logic we, input logic [15:0] a, input logic [7:0] d,
                          input bit chk_d, input logic [7:0] exp,
                          output int lat, output int req_c, output int ack_c);
        ldr_exp_t e;
        int n = 0;
        e.chk = chk_d; e.d = exp;
        ldr_q.push_back(e);
        ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
        req_c = cyc;
        do begin
            @(negedge clk); n++;
        end while (!ldr_ack && n < 40);
        ldr_req = 1'b0;
        lat = n; ack_c = cyc;
        if (!ldr_ack) begin
            n_cmp++; n_bad++;
            $display("FAIL ldr_ack_bound: no ack after %0d cycles, expected ack", n);
        end
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rc, ac, prev_ac, start_c, end_c, hi, wr, a0;
        reset_n = 1'b0;
        cpu_addr = 16'h0200; cpu_we = 1'b0; cpu_dout = 8'h00;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0000; ldr_wdata = 8'h00; ldr_hold = 1'b0;
        preload(16'h0200, 8'h5A);
        preload(16'h0300, 8'h00);
        preload(16'h0400, 8'h77);
        preload(16'h0500, 8'h42);

        // reset state
        ldr_hold = 1'b1; cpu_we = 1'b1; #1;
        chk("rst_rdy_hold", int'(cpu_rdy), 0);
        chk("rst_we_hold", int'(mem_we), 0);
        ldr_hold = 1'b0; cpu_we = 1'b0; #1;
        chk("rst_rdy", int'(cpu_rdy), 1);
        chk("rst_mem_addr", int'(mem_addr), 32'h0200);
        chk("rst_ack", int'(ldr_ack), 0);
        chk("rst_rdata", int'(ldr_rdata), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // CPU-only reads
        start_c = cyc;
        for (int i = 0; i < 5; i++) cpu_acc(16'h0200, 1'b0, 8'h00, 1'b1, 8'h5A);
        cpu_trk = 1'b0;
        hi = 0;
        for (int c = start_c; c < cyc; c++) hi += lg_rdy(c) ? 1 : 0;
        chk("t1_rdy_cycles", hi, cyc - start_c);
        chk("t1_no_ack", ack_cnt, 0);

        // loader write under CPU stream, hold=0
        fork
            ldr_op(1'b1, 16'h0300, 8'hA5, 1'b0, 8'h00, lat, rc, ac);
            for (int i = 0; i < 12; i++) cpu_acc(16'h0200, 1'b0, 8'h00, 1'b1, 8'h5A);
        join
        cpu_trk = 1'b0;
        chk("t2_latency", lat, MAX_RUN + 2);
        chk("t2_we_before", int'(lg_we(rc + 3)), 0);
        chk("t2_we_ldr", int'(lg_we(rc + 4)), 1);
        chk("t2_we_ret", int'(lg_we(rc + 5)), 0);
        hi = 0;
        for (int c = rc; c < rc + 10; c++) hi += lg_rdy(c) ? 0 : 1;
        chk("t2_stall_len", hi, 2);
        chk("t2_rdy_ldr", int'(lg_rdy(rc + 4)), 0);
        chk("t2_rdy_after", int'(lg_rdy(rc + 6)), 1);
        chk("t2_ack_pos", int'(lg_ack(rc + 6)), 1);
        chk("t2_ack_early", int'(lg_ack(rc + 5)), 0);
        chk("t2_ack_pulse", int'(lg_ack(rc + 7)), 0);
        cpu_acc(16'h0300, 1'b0, 8'h00, 1'b1, 8'hA5);
        cpu_trk = 1'b0;

        // CPU write stalled by the loader slot; loader reads old data
        fork
            ldr_op(1'b0, 16'h0400, 8'h00, 1'b1, 8'h77, lat, rc, ac);
            begin
                for (int i = 0; i < 4; i++) cpu_acc(16'h0200, 1'b0, 8'h00, 1'b0, 8'h00);
                cpu_acc(16'h0400, 1'b1, 8'h11, 1'b0, 8'h00);
                cpu_acc(16'h0200, 1'b0, 8'h00, 1'b0, 8'h00);
            end
        join
        chk("t3_latency", lat, MAX_RUN + 2);
        chk("t3_write_once", wr0400_cnt, 1);
        chk("t3_write_cycle", wr0400_cyc, rc + 6);
        cpu_acc(16'h0400, 1'b0, 8'h00, 1'b1, 8'h11);
        cpu_trk = 1'b0;

        // bootload mode: back-to-back loader writes with the CPU held
        ldr_hold = 1'b1;
        cpu_addr = 16'h0500; cpu_we = 1'b1; cpu_dout = 8'hEE; cpu_trk = 1'b0;
        start_c = cyc;
        @(negedge clk);
        prev_ac = 0;
        for (int i = 0; i < 256; i++) begin
            ldr_op(1'b1, 16'(i), 8'(i) ^ 8'hC3, 1'b0, 8'h00, lat, rc, ac);
            chk("t4_latency", lat, 3);
            if (i > 0) chk("t4_ack_spacing", ac - prev_ac, 4);
            prev_ac = ac;
            @(negedge clk);
        end
        end_c = cyc;
        hi = 0; wr = 0;
        for (int c = start_c; c < end_c; c++) begin
            hi += lg_rdy(c) ? 1 : 0;
            wr += lg_we(c) ? 1 : 0;
        end
        chk("t4_rdy_high", hi, 0);
        chk("t4_write_count", wr, 256);
        chk("t4_ram_00", int'(ram[16'h0000]), 32'hC3);
        chk("t4_ram_80", int'(ram[16'h0080]), 32'h43);
        chk("t4_ram_ff", int'(ram[16'h00FF]), 32'h3C);
        chk("t4_cpu_wr_blocked", int'(ram[16'h0500]), 32'h42);
        cpu_we = 1'b0;
        @(negedge clk);
        ldr_hold = 1'b0;
        cpu_acc(16'h0500, 1'b0, 8'h00, 1'b1, 8'h42);
        cpu_trk = 1'b0;

        // reset during the loader slot aborts the transaction
        cpu_acc(16'h0200, 1'b0, 8'h00, 1'b0, 8'h00);
        ldr_op(1'b0, 16'h0200, 8'h00, 1'b1, 8'h5A, lat, rc, ac);
        chk("t5_latency_pre", lat, MAX_RUN + 2);
        @(negedge clk);
        ldr_we = 1'b0; ldr_addr = 16'h0300; ldr_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_in_ldr_addr", int'(mem_addr), 32'h0300);
        chk("t5_in_ldr_rdy", int'(cpu_rdy), 0);
        reset_n = 1'b0; ldr_req = 1'b0;
        #1;
        chk("t5_rst_rdy", int'(cpu_rdy), 1);
        chk("t5_rst_addr", int'(mem_addr), int'(cpu_addr));
        chk("t5_rst_rdata", int'(ldr_rdata), 0);
        a0 = ack_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_no_ack", ack_cnt, a0);
        chk("t5_rdata_zero", int'(ldr_rdata), 0);
        ldr_op(1'b0, 16'h0300, 8'h00, 1'b1, 8'hA5, lat, rc, ac);
        chk("t5_latency_post", lat, MAX_RUN + 2);

        repeat (3) @(negedge clk);
        chk("cpu_queue_empty", cpu_q.size(), 0);
        chk("ldr_queue_empty", ldr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
